// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a handshaked, registered output.
// Single-cycle ops take one cycle. The optional iterative multiplier (opcode 1110)
// is built only when the macro ALU_MUL_EN is defined. Without it, 1110 acts as an
// undefined opcode.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LSR = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1101;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1110;
  // One extra count beyond the last iteration moves the accumulator to the output
  localparam logic [SHW:0] MUL_LAST = (SHW+1)'(WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DONE
`ifdef ALU_MUL_EN
    , S_MUL
`endif
  } state_t;

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0] mul_b_q;
  logic [WIDTH-1:0] mul_acc_q;
  logic [SHW:0]     mul_cnt_q;
`endif

  logic signed [WIDTH-1:0] op1_s;
  logic signed [WIDTH-1:0] op2_s;
  logic        [WIDTH-1:0] add_res;
  logic        [WIDTH-1:0] sub_res;
  logic        [SHW-1:0]   shamt;
  logic        [WIDTH-1:0] res_d;
  logic                    ovf_d;
  logic                    accept;

  assign op1_s   = op1;
  assign op2_s   = op2;
  assign add_res = op1 + op2;
  assign sub_res = op1 - op2;
  assign shamt   = op2[SHW-1:0];

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

  // Single-cycle result and signed-overflow for the incoming opcode
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (alu_op)
      OP_AND: res_d = op1 & op2;
      OP_OR:  res_d = op1 | op2;
      OP_ADD: begin
        res_d = add_res;
        ovf_d = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = sub_res;
        ovf_d = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, (op1_s < op2_s)};
      OP_LSR: res_d = op1 >> shamt;
      OP_LSL: res_d = op1 << shamt;
      OP_ASR: res_d = $unsigned(op1_s >>> shamt);
      OP_XOR: res_d = op1 ^ op2;
      default: begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  // Control FSM with registered outputs and multiply sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef ALU_MUL_EN
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_acc_q   <= '0;
      mul_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (alu_op == OP_MUL) begin
              state_q     <= S_MUL;
              out_valid_q <= 1'b0;
              mul_a_q     <= op1;
              mul_b_q     <= op2;
              mul_acc_q   <= '0;
              mul_cnt_q   <= '0;
            end else
`endif
            begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              zero_q      <= (res_d == '0);
              ovf_q       <= ovf_d;
            end
          end else if ((state_q == S_DONE) && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          if (mul_cnt_q == MUL_LAST) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_acc_q;
            zero_q      <= (mul_acc_q == '0);
            ovf_q       <= 1'b0;
          end else begin
            if (mul_b_q[0]) mul_acc_q <= mul_acc_q + mul_a_q;
            mul_a_q   <= mul_a_q << 1;
            mul_b_q   <= mul_b_q >> 1;
            mul_cnt_q <= mul_cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven checks of alu_mc (WIDTH=32) plus hand-written
// handshake, multiply and reset sequences.
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;

  int n_chk  = 0;
  int n_fail = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic bad;

    vt[0]  = '{4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0};
    vt[1]  = '{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0};
    vt[2]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vt[3]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vt[4]  = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vt[5]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vt[6]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vt[7]  = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[8]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vt[9]  = '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vt[10] = '{4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vt[11] = '{4'b1000, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0};
    vt[12] = '{4'b1010, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0};
    vt[13] = '{4'b1010, 32'h4000_0000, 32'h0000_0004, 32'h0400_0000, 1'b0, 1'b0};
    vt[14] = '{4'b1001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0};
    vt[15] = '{4'b1001, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0};
    vt[16] = '{4'b1000, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[17] = '{4'b1101, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0};
    vt[18] = '{4'b1101, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1'b0};
    vt[19] = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vt[20] = '{4'b1111, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; alu_op = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Back-to-back single-cycle ops with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; alu_op = vt[i].op; op1 = vt[i].a; op2 = vt[i].b;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d result", i), result, vt[i].res);
      chk($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vt[i].z});
      chk($sformatf("v%0d ovf", i), {31'd0, ovf}, {31'd0, vt[i].o});
    end
    in_valid = 1'b0;
    tick();
    chk("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: SUB 5-5 held for 5 cycles
    in_valid = 1'b1; alu_op = 4'b0110; op1 = 32'd5; op2 = 32'd5; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'h1; alu_op = 4'b0010;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || ovf !== 1'b0 || in_ready !== 1'b0)
        bad = 1'b1;
      tick();
    end
    chk("backpressure hold", {31'd0, bad}, 32'd0);
    chk("bp result", result, 32'd0);
    chk("bp zero", {31'd0, zero}, 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; alu_op = 4'b0010; op1 = 32'd2; op2 = 32'd3;
    #1;
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp next out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp next result", result, 32'd5);
    tick();

    // Multiply 7 * -3
    in_valid = 1'b1; alu_op = 4'b1110; op1 = 32'd7; op2 = 32'hFFFF_FFFD;
    #1;
    chk("mul accept in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; op1 = '0; op2 = '0;
    n = 0; bad = 1'b0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (in_ready !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
`ifdef ALU_MUL_EN
    chk("mul latency", n, 32'd33);
    chk("mul in_ready low", {31'd0, bad}, 32'd0);
    chk("mul result", result, 32'hFFFF_FFEB);
    chk("mul zero", {31'd0, zero}, 32'd0);
`else
    chk("nomul latency", n, 32'd0);
    chk("nomul result", result, 32'd0);
    chk("nomul zero", {31'd0, zero}, 32'd1);
`endif
    chk("mul out_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Reset in the middle of an operation
`ifdef ALU_MUL_EN
    in_valid = 1'b1; alu_op = 4'b1110; op1 = 32'd9; op2 = 32'd9; out_ready = 1'b1;
`else
    in_valid = 1'b1; alu_op = 4'b0010; op1 = 32'd9; op2 = 32'd9; out_ready = 1'b0;
`endif
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst result", result, 32'd0);
    repeat (2) tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("post rst in_ready", {31'd0, in_ready}, 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("no stale output", {31'd0, bad}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
